// File: rtl/siso_pkg.sv
// ============================================================================
// Module      : siso_pkg
// Description : Shared definitions for the SISO loopback sequencer family:
//               default word/chain sizes and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package siso_pkg;

    // Default sizing for a word and for the attached SISO chain.
    localparam int c_def_width = 8;
    localparam int c_def_depth = 4;

    // Controller state encoding.
    typedef logic [0:0] state_t;
    localparam state_t c_idle  = 1'b0;
    localparam state_t c_shift = 1'b1;

endpackage : siso_pkg

`default_nettype wire

// File: rtl/siso_bit_counter.sv
// ============================================================================
// Module      : siso_bit_counter
// Description : Up-counter for serial sequencers with synchronous clear,
//               count enable and a terminal-count flag.
//   clk   in   clock, rising edge
//   clear in   synchronous clear to zero (priority over en)
//   en    in   increment enable
//   cnt   out  current count
//   tc    out  high while cnt equals TERMINAL
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module siso_bit_counter #(
    parameter int CNT_W    = 4,
    parameter int TERMINAL = 11
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] c_term = CNT_W'(TERMINAL);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign cnt = r_cnt;
    assign tc  = (r_cnt == c_term);

endmodule : siso_bit_counter

`default_nettype wire

// File: rtl/siso_seq_ctrl.sv
// ============================================================================
// Module      : siso_seq_ctrl
// Description : Sequencer for an external free-running DEPTH-stage SISO shift
//               register. Accepts a parallel word on a valid/ready handshake,
//               drives it MSB-first on si, recaptures it from so after the
//               chain delay and returns it on out_data with a mismatch flag.
//   clk       in   clock, rising edge
//   clear     in   synchronous active-high reset
//   abort     in   synchronous frame abort
//   in_valid  in   producer word valid
//   in_data   in   producer word
//   in_ready  out  controller can accept a word
//   si        out  serial data to the SISO register
//   so        in   serial data from the SISO register
//   reg_clear out  clear strobe to the SISO register
//   busy      out  frame in progress
//   out_valid out  one-cycle pulse, out_data/out_err valid
//   out_data  out  recaptured word
//   out_err   out  recaptured word differs from transmitted word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module siso_seq_ctrl
    import siso_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int DEPTH = c_def_depth
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             si,
    input  logic             so,
    output logic             reg_clear,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    // Frame spans cnt = 0 .. WIDTH+DEPTH-1; the counter never wraps.
    localparam int               c_cnt_w = $clog2(WIDTH + DEPTH);
    localparam int               c_last  = WIDTH + DEPTH - 1;
    localparam logic [c_cnt_w-1:0] c_width_cnt = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_tx;
    logic [WIDTH-1:0]   r_rx;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_err;

    logic [c_cnt_w-1:0] w_cnt;
    logic               w_tc;
    logic               w_in_shift;
    logic               w_accept;
    logic               w_capture;
    logic               w_cnt_clr;
    logic [WIDTH-1:0]   w_tx_shift;
    logic [WIDTH:0]     w_rx_ext;
    logic [WIDTH-1:0]   w_rx_next;

    assign w_in_shift = (r_state == c_shift);

    // Abort and clear both win over a coincident handshake, so ready is
    // withdrawn in those cycles to keep valid&ready equal to a real accept.
    assign in_ready  = !w_in_shift && !clear && !abort;
    assign w_accept  = in_valid && in_ready;

    // Counter idles at zero outside SHIFT and is zeroed on every exit.
    assign w_cnt_clr = clear || abort || w_tc || !w_in_shift;

    siso_bit_counter #(
        .CNT_W    (c_cnt_w),
        .TERMINAL (c_last)
    ) u_cnt (
        .clk   (clk),
        .clear (w_cnt_clr),
        .en    (w_in_shift),
        .cnt   (w_cnt),
        .tc    (w_tc)
    );

    // MSB-first: shifting tx left by cnt places bit WIDTH-1-cnt at the top.
    assign w_tx_shift = r_tx << w_cnt;
    assign si = w_in_shift && (w_cnt < c_width_cnt) && w_tx_shift[WIDTH-1];

    // Bit sent at cnt=i appears on so at cnt=i+DEPTH.
    assign w_capture = w_in_shift && (w_cnt >= c_depth_cnt);
    assign w_rx_ext  = {r_rx, so};
    assign w_rx_next = w_rx_ext[WIDTH-1:0];

    assign reg_clear = clear || abort;
    assign busy      = w_in_shift;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= c_idle;
            r_tx        <= '0;
            r_rx        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_tx    <= in_data;
                        r_rx    <= '0;
                        r_state <= c_shift;
                    end
                end
                c_shift: begin
                    if (abort) begin
                        // Frame dropped; previous result stays visible.
                        r_state <= c_idle;
                    end else begin
                        if (w_capture) begin
                            r_rx <= w_rx_next;
                        end
                        if (w_tc) begin
                            r_out_data  <= w_rx_next;
                            r_out_err   <= (w_rx_next != r_tx);
                            r_out_valid <= 1'b1;
                            r_state     <= c_idle;
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule : siso_seq_ctrl

`default_nettype wire

// File: tb/tb_siso_seq_ctrl.sv
// ============================================================================
// Module      : tb_siso_seq_ctrl
// Description : Directed self-checking bench for siso_seq_ctrl with a
//               behavioural SISO chain on the loopback, plus a minimal
//               WIDTH=1/DEPTH=1 build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_siso_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = WIDTH + DEPTH;   // edges after the accepting edge

    logic             clk = 1'b0;
    logic             clear;
    logic             abort;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             si;
    logic             so;
    logic             reg_clear;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    logic             force_so0;
    logic [DEPTH-1:0] sreg;

    // Minimal build
    logic             t_in_valid;
    logic [0:0]       t_in_data;
    logic             t_in_ready;
    logic             t_si;
    logic             t_so;
    logic             t_reg_clear;
    logic             t_busy;
    logic             t_out_valid;
    logic [0:0]       t_out_data;
    logic             t_out_err;
    logic             t_sreg;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    siso_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .clear(clear), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .si(si), .so(so), .reg_clear(reg_clear), .busy(busy),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err)
    );

    siso_seq_ctrl #(.WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .clear(clear), .abort(abort),
        .in_valid(t_in_valid), .in_data(t_in_data), .in_ready(t_in_ready),
        .si(t_si), .so(t_so), .reg_clear(t_reg_clear), .busy(t_busy),
        .out_valid(t_out_valid), .out_data(t_out_data), .out_err(t_out_err)
    );

    // External SISO chains
    always_ff @(posedge clk) begin
        if (reg_clear) sreg <= '0;
        else           sreg <= DEPTH'({sreg, si});
        if (t_reg_clear) t_sreg <= 1'b0;
        else             t_sreg <= t_si;
    end
    assign so   = force_so0 ? 1'b0 : sreg[DEPTH-1];
    assign t_so = t_sreg;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1; abort = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
        t_in_valid = 1'b0; t_in_data = 1'b0; force_so0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready c%0d: got %b want 0", i, in_ready); end
            n_cmp++; if (reg_clear !== 1'b1) begin n_bad++; $display("FAIL rst_regclr c%0d: got %b want 1", i, reg_clear); end
            n_cmp++; if (si !== 1'b0) begin n_bad++; $display("FAIL rst_si c%0d: got %b want 0", i, si); end
            n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_ov_busy c%0d: got %b%b want 00", i, out_valid, busy); end
            n_cmp++; if (out_data !== 8'h00 || out_err !== 1'b0) begin n_bad++; $display("FAIL rst_out c%0d: got %h/%b want 00/0", i, out_data, out_err); end
        end
        clear = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", in_ready); end
        n_cmp++; if (reg_clear !== 1'b0) begin n_bad++; $display("FAIL rst_regclr_after: got %b want 0", reg_clear); end
        step();
    endtask

    task automatic test_single();
        logic [7:0] exp_si;
        exp_si = 8'b1010_0101;   // A5 bits sent MSB first
        in_valid = 1'b1; in_data = 8'hA5;
        step();                  // accepting edge
        in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < WIDTH; i++) begin
            n_cmp++; if (si !== exp_si[WIDTH-1-i] || busy !== 1'b1) begin n_bad++; $display("FAIL single_si cnt%0d: got si=%b busy=%b want si=%b busy=1", i, si, busy, exp_si[WIDTH-1-i]); end
            step();
        end
        for (int i = WIDTH; i < LAT; i++) begin
            n_cmp++; if (out_valid !== 1'b0 || si !== 1'b0) begin n_bad++; $display("FAIL single_early cnt%0d: got ov=%b si=%b want 0/0", i, out_valid, si); end
            step();
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_ov: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 8'hA5 || out_err !== 1'b0) begin n_bad++; $display("FAIL single_data: got %h/%b want a5/0", out_data, out_err); end
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL single_idle: got busy=%b rdy=%b want 0/1", busy, in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'hA5) begin n_bad++; $display("FAIL single_hold: got ov=%b data=%h want 0/a5", out_valid, out_data); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = 8'h3C;
        step();
        in_data = 8'hFF;         // must not disturb the frame in flight
        repeat (LAT) step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_err !== 1'b0) begin n_bad++; $display("FAIL b2b_first: got ov=%b %h/%b want 1 3c/0", out_valid, out_data, out_err); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        step();                  // second word accepted here
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_accept: got busy=%b ov=%b want 1/0", busy, out_valid); end
        repeat (LAT - 1) step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_early: got %b want 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hFF || out_err !== 1'b0) begin n_bad++; $display("FAIL b2b_second: got ov=%b %h/%b want 1 ff/0", out_valid, out_data, out_err); end
        step();
    endtask

    task automatic test_fault();
        force_so0 = 1'b1;
        in_valid = 1'b1; in_data = 8'h81;
        step();
        in_valid = 1'b0;
        repeat (LAT) step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h00 || out_err !== 1'b1) begin n_bad++; $display("FAIL fault: got ov=%b %h/%b want 1 00/1", out_valid, out_data, out_err); end
        force_so0 = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int seen;
        in_valid = 1'b1; in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        repeat (5) step();       // now at cnt=5
        abort = 1'b1;
        #1;
        n_cmp++; if (reg_clear !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL abort_strobe: got rc=%b busy=%b want 1/1", reg_clear, busy); end
        step();
        abort = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1 || reg_clear !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got busy=%b rdy=%b rc=%b want 0/1/0", busy, in_ready, reg_clear); end
        n_cmp++; if (out_data !== 8'h00 || out_err !== 1'b1) begin n_bad++; $display("FAIL abort_hold: got %h/%b want 00/1", out_data, out_err); end
        seen = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            if (out_valid === 1'b1) seen++;
            step();
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_no_ov: got %0d pulses want 0", seen); end
        in_valid = 1'b1; in_data = 8'h0F;
        step();
        in_valid = 1'b0;
        repeat (LAT) step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h0F || out_err !== 1'b0) begin n_bad++; $display("FAIL abort_next: got ov=%b %h/%b want 1 0f/0", out_valid, out_data, out_err); end
        step();
    endtask

    task automatic test_clear_mid();
        int seen;
        in_valid = 1'b1; in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        repeat (10) step();      // now at cnt=10
        clear = 1'b1;
        #1;
        n_cmp++; if (reg_clear !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL clr_strobe: got rc=%b rdy=%b want 1/0", reg_clear, in_ready); end
        step();
        clear = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0 || busy !== 1'b0 || si !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_state: got ov=%b %h/%b busy=%b si=%b rdy=%b want 0 00/0 0 0 1", out_valid, out_data, out_err, busy, si, in_ready); end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid === 1'b1) seen++;
            step();
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL clr_no_ov: got %0d pulses want 0", seen); end
    endtask

    task automatic test_minimal();
        logic [1:0] words;
        words = 2'b10;
        for (int w = 0; w < 2; w++) begin
            t_in_valid = 1'b1; t_in_data = words[1-w];
            step();
            t_in_valid = 1'b0;
            n_cmp++; if (t_si !== words[1-w]) begin n_bad++; $display("FAIL min_si w%0d: got %b want %b", w, t_si, words[1-w]); end
            step();
            n_cmp++; if (t_out_valid !== 1'b0) begin n_bad++; $display("FAIL min_early w%0d: got %b want 0", w, t_out_valid); end
            step();
            n_cmp++; if (t_out_valid !== 1'b1 || t_out_data !== words[1-w] || t_out_err !== 1'b0) begin n_bad++; $display("FAIL min_out w%0d: got ov=%b %b/%b want 1 %b/0", w, t_out_valid, t_out_data, t_out_err, words[1-w]); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fault();
        test_abort();
        test_clear_mid();
        test_minimal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_siso_seq_ctrl

`default_nettype wire
